// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder that assembles R/I-format words from request fields
// and writes them to consecutive instruction-memory words until the memory is full.
module instr_encoder_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W+1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [31:0]         data_q, data_d;

    logic                legal;
    logic                accept;
    logic [ADDR_W:0]     count_inc;
    logic                last_write;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    word = {6'b001000, rs, rt, imm};
            3'd2:    word = {6'b000100, rs, rt, imm};
            3'd3:    word = {6'b001010, rs, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    assign legal      = (kind_i[2] == 1'b0);
    assign accept     = req_valid_i && (state_q == S_IDLE) && !clear_i;
    assign count_inc  = count_q + (ADDR_W+1)'(1);
    assign last_write = (count_inc == DEPTH_CNT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a soft clear always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept && legal) state_d = S_WRITE;
                S_WRITE: state_d = last_write ? S_FULL : S_IDLE;
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        imem_we_o   = (state_q == S_WRITE);
        full_o      = (state_q == S_FULL);
        imem_addr_o = {wr_ptr_q, 2'b00};
        imem_data_o = data_q;
        count_o     = count_q;
        err_o       = err_q;
    end

    // Datapath next-state; the pointer holds on the final write so it never wraps
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        data_d   = data_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (accept && !legal) begin
                err_d = 1'b1;
            end
            if (accept && legal) begin
                data_d = encode(kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i);
            end
            if (state_q == S_WRITE) begin
                count_d = count_inc;
                if (!last_write) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

endmodule
